// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// for the shared-ALU datapath, counts retired instructions and flags illegal opcodes.
module mc_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned BEQ_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       rf_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             dm_re,
  output logic             dm_we,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,  S_FETCH = 4'd1,  S_DCD  = 4'd2,  S_EXE_R = 4'd3,
    S_EXE_I = 4'd4,  S_ADR   = 4'd5,  S_MRD  = 4'd6,  S_MWR   = 4'd7,
    S_WB_R  = 4'd8,  S_WB_I  = 4'd9,  S_WB_M = 4'd10, S_BR    = 4'd11,
    S_JMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101,
                         OP_LUI   = 6'b001111, OP_LW    = 6'b100011, OP_SW  = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_J     = 6'b000010;

  state_t           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [1:0]       br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    case (f)
      6'b100011: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic r_legal(input logic [5:0] f);
    return (f == 6'b100001) || (f == 6'b100011) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      funct_q  <= '0;
      br_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      cnt_q    <= cnt_d;
      if (state_q == S_DCD) begin
        op_q    <= op;
        funct_q <= funct;
      end
    end
  end

  // Decode in S_DCD looks at the live IR fields; later states use the latched copy.
  always_comb begin
    state_d  = state_q;
    br_cnt_d = '0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        case (op)
          OP_RTYPE: begin
            if (r_legal(funct)) state_d = S_EXE_R;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_ADDIU, OP_ORI, OP_LUI: state_d = S_EXE_I;
          OP_LW, OP_SW:             state_d = S_ADR;
          OP_BEQ:                   state_d = S_BR;
          OP_J:                     state_d = S_JMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXE_R: state_d = S_WB_R;
      S_EXE_I: state_d = S_WB_I;
      S_ADR:   state_d = (op_q == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   if (mem_rdy) state_d = S_WB_M;
      S_MWR:   if (mem_rdy) state_d = S_FETCH;
      S_BR: begin
        if (32'(br_cnt_q) >= BEQ_DELAY) state_d = S_FETCH;
        else                            br_cnt_d = br_cnt_q + 2'd1;
      end
      S_WB_R, S_WB_I, S_WB_M, S_JMP: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_WB_R, S_WB_I, S_WB_M, S_MWR, S_BR, S_JMP});
  assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    rf_dst    = 2'b00;
    wd_sel    = 2'b00;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    alu_op    = 3'b000;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_EXE_R: alu_op = r_alu_op(funct_q);
      S_WB_R: begin
        rf_we  = 1'b1;
        rf_dst = 2'b01;
        alu_op = r_alu_op(funct_q);
      end
      S_EXE_I: begin
        alu_src_b = 1'b1;
        ext_op    = (op_q == OP_ADDIU);
        alu_op    = (op_q == OP_ORI) ? 3'b011 : 3'b000;
      end
      S_WB_I: begin
        rf_we  = 1'b1;
        wd_sel = (op_q == OP_LUI) ? 2'b10 : 2'b00;
      end
      S_ADR, S_MRD, S_MWR: begin
        alu_src_b = 1'b1;
        ext_op    = 1'b1;
        dm_re     = (state_q == S_MRD);
        dm_we     = (state_q == S_MWR);
      end
      S_WB_M: begin
        rf_we  = 1'b1;
        wd_sel = 2'b01;
      end
      S_BR: begin
        // Only the first BR cycle may load the PC; delay cycles just idle.
        alu_op = 3'b001;
        pc_src = 2'b01;
        pc_we  = zero && (br_cnt_q == 2'd0);
      end
      S_JMP: begin
        pc_we  = 1'b1;
        pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is expanded into an expected
// per-cycle trace of state + control outputs, then replayed against the DUT.
module tb_mc_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       op, funct;
  logic             zero, mem_rdy;
  logic             pc_we, ir_we, rf_we, alu_src_b, ext_op, dm_re, dm_we, illegal;
  logic [1:0]       pc_src, rf_dst, wd_sel;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [20:0]      got_v;

  mc_ctrl #(.CNT_W(CNT_W), .BEQ_DELAY(0)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we), .rf_dst(rf_dst),
    .wd_sel(wd_sel), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .dm_re(dm_re), .dm_we(dm_we), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign got_v = {state, pc_we, pc_src, ir_we, rf_we, rf_dst, wd_sel,
                  alu_src_b, ext_op, alu_op, dm_re, dm_we, illegal};

  typedef struct {
    logic [20:0] v;
    logic        rdy;
    logic        z;
  } ent_t;

  ent_t             tr[$];
  logic             retire_m;
  logic [CNT_W-1:0] cnt_m;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] pk(input int st, input int pcw, input int pcs, input int irw,
                                     input int rfw, input int rfd, input int wds, input int asb,
                                     input int ext, input int aop, input int re, input int we,
                                     input int ill);
    return {4'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(rfw), 2'(rfd), 2'(wds),
            1'(asb), 1'(ext), 3'(aop), 1'(re), 1'(we), 1'(ill)};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic add(input logic [20:0] v, input logic rdy, input logic z);
    ent_t e;
    e.v = v; e.rdy = rdy; e.z = z;
    tr.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
  // zf: 0/1 forces the zero flag seen in BR, 2 leaves it random.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int nwait, input int zf);
    int   aop;
    logic z;
    logic mem_wr;
    tr.delete();
    retire_m = 1'b1;
    add(pk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
    if (o == 6'd0 && (f == 6'd33 || f == 6'd35 || f == 6'd36 || f == 6'd37 || f == 6'd42)) begin
      aop = (f == 6'd35) ? 1 : (f == 6'd36) ? 2 : (f == 6'd37) ? 3 : (f == 6'd42) ? 4 : 0;
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
      add(pk(3, 0, 0, 0, 0, 0, 0, 0, 0, aop, 0, 0, 0), rb(), rb());
      add(pk(8, 0, 0, 0, 1, 1, 0, 0, 0, aop, 0, 0, 0), rb(), rb());
    end else if (o == 6'd9 || o == 6'd13 || o == 6'd15) begin
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
      add(pk(4, 0, 0, 0, 0, 0, 0, 1, (o == 6'd9) ? 1 : 0, (o == 6'd13) ? 3 : 0, 0, 0, 0),
          rb(), rb());
      add(pk(9, 0, 0, 0, 1, 0, (o == 6'd15) ? 2 : 0, 0, 0, 0, 0, 0, 0), rb(), rb());
    end else if (o == 6'd35 || o == 6'd43) begin
      mem_wr = (o == 6'd43);
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
      add(pk(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), rb(), rb());
      for (int w = 0; w <= nwait; w++)
        add(pk(mem_wr ? 7 : 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, mem_wr ? 0 : 1, mem_wr ? 1 : 0, 0),
            (w == nwait), rb());
      if (!mem_wr) add(pk(10, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), rb(), rb());
    end else if (o == 6'd4) begin
      z = (zf == 2) ? rb() : 1'(zf);
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
      add(pk(11, z ? 1 : 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), rb(), z);
    end else if (o == 6'd2) begin
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
      add(pk(12, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
    end else begin
      retire_m = 1'b0;
      add(pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rb(), rb());
    end
  endtask

  // Replays the trace from FETCH (entered at posedge+1); IR fields are scrambled
  // after decode so later states must rely on the latched copy.
  task automatic run_trace(input int nmax);
    for (int i = 0; i < tr.size() && i < nmax; i++) begin
      mem_rdy = tr[i].rdy;
      zero    = tr[i].z;
      @(negedge clk);
      chk($sformatf("out[%0d]", i), 32'(got_v), 32'(tr[i].v));
      chk($sformatf("cnt[%0d]", i), 32'(instr_cnt), 32'(cnt_m));
      @(posedge clk);
      #1;
      if (i == 1) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int nwait, input int zf);
    op    = o;
    funct = f;
    build(o, f, nwait, zf);
    run_trace(tr.size());
    if (retire_m) cnt_m = cnt_m + 1'b1;
    $display("instr op=%0d funct=%0d cycles=%0d retire=%0d cnt=%0d",
             o, f, tr.size(), retire_m, cnt_m);
    chk("after_cnt", 32'(instr_cnt), 32'(cnt_m));
    chk("after_state", 32'(state), 32'd1);
  endtask

  logic [5:0] ops_t[13] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd13, 6'd15,
                            6'd35, 6'd43, 6'd4, 6'd2, 6'd63};
  logic [5:0] fns_t[5]  = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd42};

  initial begin
    logic [5:0] ro, rf;
    rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
    cnt_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(got_v), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("idle", 32'(got_v), 32'd0);
    @(posedge clk);
    #1;

    do_instr(6'd0, 6'd33, 0, 2);
    do_instr(6'd35, 6'd0, 3, 2);
    do_instr(6'd4, 6'd0, 0, 1);
    do_instr(6'd4, 6'd0, 0, 0);
    do_instr(6'd2, 6'd0, 0, 2);
    do_instr(6'd15, 6'd0, 0, 2);
    do_instr(6'd63, 6'd0, 0, 2);
    do_instr(6'd0, 6'd0, 0, 2);
    do_instr(6'd43, 6'd0, 2, 2);
    do_instr(6'd43, 6'd0, 0, 2);

    for (int k = 0; k < 40; k++) begin
      ro = ops_t[$urandom_range(12, 0)];
      rf = (ro == 6'd0 && $urandom_range(3, 0) != 0) ? fns_t[$urandom_range(4, 0)] : 6'($urandom);
      if ($urandom_range(9, 0) == 0) ro = 6'($urandom);
      do_instr(ro, rf, $urandom_range(3, 0), 2);
    end

    while (cnt_m != '1) do_instr(6'd0, 6'd37, 0, 2);
    do_instr(6'd0, 6'd42, 0, 2);
    chk("wrap", 32'(instr_cnt), 32'd0);
    do_instr(6'd9, 6'd0, 0, 2);

    op = 6'd35;
    funct = 6'd0;
    build(6'd35, 6'd0, 5, 2);
    run_trace(4);
    chk("pre_rst_state", 32'(state), 32'd6);
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_dm_re", 32'(dm_re), 32'd0);
    chk("arst_cnt", 32'(instr_cnt), 32'd0);
    cnt_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_idle", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_fetch", 32'(state), 32'd1);
    do_instr(6'd0, 6'd33, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
